// File: rtl/tx_frame_sched_pkg.sv
// Shared header codes and frame-select type for the TX frame scheduler.
package rifl_tx_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;
  localparam logic [1:0] HDR_IDLE = 2'b00;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_CTRL,
    SEL_DATA
  } frame_sel_e;

  // Header code stamped on a frame of the given type.
  function automatic logic [1:0] sel_hdr(input frame_sel_e sel);
    case (sel)
      SEL_CTRL: sel_hdr = HDR_CTRL;
      SEL_DATA: sel_hdr = HDR_DATA;
      default:  sel_hdr = HDR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tx_frame_sched_serializer.sv
// Frame serializer: loads a full frame and shifts it out MSB beat first.
// Owns the beat counter; o_last marks the slot's final beat (the decision cycle).
module frame_serializer #(
  parameter int unsigned FRAME_WIDTH = 256,
  parameter int unsigned DWIDTH      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [FRAME_WIDTH-1:0] i_frame,
  output logic                   o_last,
  output logic                   o_sof,
  output logic [DWIDTH-1:0]      o_data
);

  localparam int unsigned BEATS = FRAME_WIDTH / DWIDTH;
  localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  logic [FRAME_WIDTH-1:0] r_shift;
  logic [BCW-1:0]         r_bcnt;
  logic                   r_active;

  // Shift register, beat counter and frame-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bcnt   <= LAST_BEAT;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_shift  <= i_frame;
      r_bcnt   <= '0;
      r_active <= 1'b1;
    end else begin
      r_shift <= r_shift << DWIDTH;
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  assign o_last = (r_bcnt == LAST_BEAT);
  assign o_sof  = r_active && (r_bcnt == '0);
  assign o_data = r_shift[FRAME_WIDTH-1 -: DWIDTH];

endmodule

// File: rtl/tx_frame_sched.sv
// TX frame scheduler: per-slot arbitration between control, forced idle
// (clock compensation), user data and idle; stamps header, clears CRC field.
module tx_frame_sched
  import rifl_tx_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = 256,
  parameter int unsigned DWIDTH      = 64,
  parameter int unsigned CRC_WIDTH   = 12,
  parameter int unsigned CC_PERIOD   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_WIDTH-1:0] ctrl_frame,
  input  logic                   ctrl_valid,
  output logic                   ctrl_ready,
  input  logic [FRAME_WIDTH-1:0] data_frame,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic                   pause,
  output logic                   sof,
  output logic [DWIDTH-1:0]      data_out,
  output logic                   cc_inserted
);

  localparam int unsigned CCW = (CC_PERIOD > 0) ? $clog2(CC_PERIOD + 1) : 1;
  localparam logic [CCW-1:0] CC_MAX = CCW'(CC_PERIOD);

  logic [CCW-1:0]         r_cc_cnt;
  logic                   w_last;
  logic                   w_decide;
  logic                   w_force;
  logic                   w_cc_ins;
  frame_sel_e             w_sel;
  logic [FRAME_WIDTH-1:0] w_frame;

  assign w_decide = w_last && !rst;
  assign w_force  = (CC_PERIOD != 0) && (r_cc_cnt == CC_MAX);

  // Slot arbitration: control > forced idle > data (unless paused) > idle.
  always_comb begin
    w_sel    = SEL_IDLE;
    w_cc_ins = 1'b0;
    if (w_decide) begin
      if (ctrl_valid) begin
        w_sel = SEL_CTRL;
      end else if (w_force) begin
        w_sel    = SEL_IDLE;
        w_cc_ins = 1'b1;
      end else if (data_valid && !pause) begin
        w_sel = SEL_DATA;
      end
    end
  end

  assign ctrl_ready  = w_decide && (w_sel == SEL_CTRL);
  assign data_ready  = w_decide && (w_sel == SEL_DATA);
  assign cc_inserted = w_cc_ins;

  // Frame assembly: pick body, stamp header, clear the encoder's CRC field.
  always_comb begin
    w_frame = '0;
    case (w_sel)
      SEL_CTRL: w_frame = ctrl_frame;
      SEL_DATA: w_frame = data_frame;
      default:  w_frame = '0;
    endcase
    w_frame[FRAME_WIDTH-1 -: 2] = sel_hdr(w_sel);
    w_frame[CRC_WIDTH-1:0]      = '0;
  end

  // Clock-compensation counter: clears on idle, saturates on busy frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc_cnt <= '0;
    end else if (w_decide) begin
      if (w_sel == SEL_IDLE) begin
        r_cc_cnt <= '0;
      end else if (r_cc_cnt != CC_MAX) begin
        r_cc_cnt <= r_cc_cnt + 1'b1;
      end
    end
  end

  frame_serializer #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .DWIDTH      (DWIDTH)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_decide),
    .i_frame (w_frame),
    .o_last  (w_last),
    .o_sof   (sof),
    .o_data  (data_out)
  );

endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench for tx_frame_sched (256/64/12, CC_PERIOD=4).
module tb_tx_frame_sched;

  localparam int unsigned FW  = 256;
  localparam int unsigned DW  = 64;
  localparam int unsigned NB  = FW / DW;
  localparam int unsigned CCP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] ctrl_frame = '0;
  logic          ctrl_valid = 1'b0;
  logic          ctrl_ready;
  logic [FW-1:0] data_frame = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          pause = 1'b0;
  logic          sof;
  logic [DW-1:0] data_out;
  logic          cc_inserted;

  tx_frame_sched #(
    .FRAME_WIDTH (FW),
    .DWIDTH      (DW),
    .CRC_WIDTH   (12),
    .CC_PERIOD   (CCP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl_frame  (ctrl_frame),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .data_frame  (data_frame),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .pause       (pause),
    .sof         (sof),
    .data_out    (data_out),
    .cc_inserted (cc_inserted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sof;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] obs_q[$];
  int            m_slot = NB - 1;
  int            m_cc   = 0;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_dr = 0;
  int            n_cc = 0;

  task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f = '0;
    for (int unsigned i = 0; i < FW / 32; i++) f = {f[FW-33:0], 32'($urandom())};
    return f;
  endfunction

  // One clock cycle: check outputs at the falling edge, advance the model.
  task automatic step();
    beat_t         b;
    logic [FW-1:0] f;
    logic [1:0]    hdr;
    int            sel;   // 0 idle, 1 ctrl, 2 data
    logic          e_cc;
    @(negedge clk);
    b = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_eq("sof", FW'(sof), FW'(b.sof));
    check_eq("data_out", FW'(data_out), FW'(b.d));
    obs_q.push_back(data_out);
    if (data_ready) n_dr++;
    if (cc_inserted) n_cc++;
    if (rst) begin
      check_eq("ctrl_ready_rst", FW'(ctrl_ready), '0);
      check_eq("data_ready_rst", FW'(data_ready), '0);
      check_eq("cc_ins_rst", FW'(cc_inserted), '0);
      exp_q.delete();
      m_slot = NB - 1;
      m_cc   = 0;
    end else if (m_slot == NB - 1) begin
      e_cc = 1'b0;
      if (ctrl_valid) sel = 1;
      else if (m_cc == CCP) begin sel = 0; e_cc = 1'b1; end
      else if (data_valid && !pause) sel = 2;
      else sel = 0;
      check_eq("ctrl_ready", FW'(ctrl_ready), FW'(sel == 1));
      check_eq("data_ready", FW'(data_ready), FW'(sel == 2));
      check_eq("cc_inserted", FW'(cc_inserted), FW'(e_cc));
      f   = (sel == 1) ? ctrl_frame : (sel == 2) ? data_frame : '0;
      hdr = (sel == 1) ? 2'b10 : (sel == 2) ? 2'b01 : 2'b00;
      f[FW-1 -: 2] = hdr;
      f[11:0]      = '0;
      for (int unsigned i = 0; i < NB; i++) exp_q.push_back({(i == 0), f[FW-1-DW*i -: DW]});
      m_cc   = (sel == 0) ? 0 : ((m_cc < CCP) ? m_cc + 1 : m_cc);
      m_slot = 0;
    end else begin
      check_eq("ctrl_ready_mid", FW'(ctrl_ready), '0);
      check_eq("data_ready_mid", FW'(data_ready), '0);
      check_eq("cc_ins_mid", FW'(cc_inserted), '0);
      m_slot++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Run idle cycles until the next cycle is a decision cycle.
  task automatic align();
    int guard = 0;
    while (m_slot != NB - 1 && guard < 16) begin
      step();
      guard++;
    end
  endtask

  initial begin
    // Reset, then idle: sof at cycles 2, 6, 10 with all-zero beats.
    steps(3);
    rst = 1'b0;
    steps(12);

    // Continuous all-ones data: 4 data frames then one forced idle.
    n_dr = 0;
    n_cc = 0;
    obs_q.delete();
    data_frame = '1;
    data_valid = 1'b1;
    steps(24);
    check_eq("beat0_ones", FW'(obs_q[1]), FW'(64'h7FFF_FFFF_FFFF_FFFF));
    check_eq("beat3_ones", FW'(obs_q[4]), FW'(64'hFFFF_FFFF_FFFF_F000));
    check_eq("dr_pulses", FW'(n_dr), FW'(5));
    check_eq("cc_pulses", FW'(n_cc), FW'(1));
    data_valid = 1'b0;
    align();

    // Control and data together: control wins, data follows next slot.
    ctrl_frame = rand_frame();
    data_frame = rand_frame();
    ctrl_valid = 1'b1;
    data_valid = 1'b1;
    step();
    ctrl_valid = 1'b0;
    steps(NB * 2 - 1);
    data_valid = 1'b0;
    align();

    // Pause blocks data; release resumes it at the next slot.
    data_frame = rand_frame();
    data_valid = 1'b1;
    pause      = 1'b1;
    n_dr = 0;
    steps(12);
    check_eq("dr_paused", FW'(n_dr), '0);
    pause = 1'b0;
    steps(8);
    data_valid = 1'b0;
    align();

    // Reset during beat 2 of a data frame: frame abandoned, not replayed.
    data_frame = rand_frame();
    data_valid = 1'b1;
    steps(3);
    data_valid = 1'b0;
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(10);

    // Randomised traffic.
    for (int i = 0; i < 240; i++) begin
      ctrl_valid = ($urandom_range(0, 3) == 0);
      data_valid = ($urandom_range(0, 1) == 1);
      pause      = ($urandom_range(0, 3) == 0);
      ctrl_frame = rand_frame();
      data_frame = rand_frame();
      step();
    end
    ctrl_valid = 1'b0;
    data_valid = 1'b0;
    pause      = 1'b0;
    steps(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
